// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM line and its capture block.
// master = capture side, slave = consumer that also sources the line.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             stuck;
  logic             overrun;

  modport master (
    input  pwm_in,
    output period, high_time, duty_pct, meas_valid, stuck, overrun
  );

  modport slave (
    output pwm_in,
    input  period, high_time, duty_pct, meas_valid, stuck, overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures period/high time in clkin cycles, derives integer duty %
// with a 7-step restoring divider, and flags a line with no edges as stuck.
module pwm_capture #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic          clkin,
  input  logic          rst_n,
  pwm_capture_if.master cap
);
  localparam int STAGES = 6;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t           state, state_nx;
  logic             sync1, pwm_s, pwm_d;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, hi_lat;
  logic             at_tmo, start, lat_hi, complete, tmo;
  logic             load, busy;
  logic [STAGES:0]  vld_pipe;
  logic [CNT_W+6:0] rem, dsh, rem_nx;
  logic             ge;
  logic [6:0]       q;
  logic [CNT_W-1:0] per_q, hi_q;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= cap.pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  assign rise   = pwm_s & ~pwm_d;
  assign fall   = ~pwm_s & pwm_d;
  assign at_tmo = (cnt == TMO);

  always_ff @(posedge clkin) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise) state_nx = HIGH;
      HIGH:    if (fall) state_nx = LOW;  else if (at_tmo) state_nx = IDLE;
      LOW:     if (rise) state_nx = HIGH; else if (at_tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // An edge in the timeout cycle wins: the timeout only fires when the expected edge is absent.
  always_comb begin
    start    = 1'b0;
    lat_hi   = 1'b0;
    complete = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: start = rise;
      HIGH: begin
        lat_hi = fall;
        tmo    = at_tmo & ~fall;
      end
      LOW: begin
        complete = rise;
        tmo      = at_tmo & ~rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      cnt    <= '0;
      hi_lat <= '0;
    end else begin
      if (start || complete) cnt <= CNT_W'(1);
      else if (tmo)          cnt <= '0;
      else if (state != IDLE) cnt <= cnt + CNT_W'(1);
      if (lat_hi) hi_lat <= cnt;
    end
  end

  // Divider: vld_pipe[k] marks quotient bit 6-k in flight; dsh carries den<<(6-k).
  assign busy   = |vld_pipe;
  assign load   = complete & ~busy;
  assign ge     = (rem >= dsh);
  assign rem_nx = ge ? (rem - dsh) : rem;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rem      <= '0;
      dsh      <= '0;
      q        <= '0;
      per_q    <= '0;
      hi_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], load};
      if (load) begin
        rem   <= {7'b0, hi_lat} * (CNT_W+7)'(100);
        dsh   <= {1'b0, cnt, 6'b0};
        per_q <= cnt;
        hi_q  <= hi_lat;
        q     <= '0;
      end else if (busy) begin
        rem <= rem_nx;
        dsh <= dsh >> 1;
        q   <= {q[5:0], ge};
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      cap.period     <= '0;
      cap.high_time  <= '0;
      cap.duty_pct   <= '0;
      cap.meas_valid <= 1'b0;
      cap.stuck      <= 1'b0;
      cap.overrun    <= 1'b0;
    end else begin
      cap.meas_valid <= 1'b0;
      cap.overrun    <= complete & busy;
      if (tmo) begin
        cap.period     <= '0;
        cap.high_time  <= '0;
        cap.duty_pct   <= (state == HIGH) ? 7'd100 : 7'd0;
        cap.stuck      <= 1'b1;
        cap.meas_valid <= 1'b1;
      end else if (vld_pipe[STAGES]) begin
        cap.period     <= per_q;
        cap.high_time  <= hi_q;
        cap.duty_pct   <= {q[5:0], ge};
        cap.meas_valid <= 1'b1;
      end
      if (start) cap.stuck <= 1'b0;
    end
  end
endmodule
